// File: rtl/blitter_pkg.sv
// Shared definitions for the sprite blitter.
// Contents:
//   state_t        - pass sequencer states
//   SCREEN_*_DEF   - default visible frame size (160x120)
//   BG_COLOUR_DEF  - default erase / clear colour
//   bus_field()    - extracts one slot's field from a packed per-slot bus
package blitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_ERASE_SEL = 3'd2,
        ST_ERASE_PIX = 3'd3,
        ST_DRAW_SEL  = 3'd4,
        ST_DRAW_PIX  = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam int SCREEN_W_DEF  = 160;
    localparam int SCREEN_H_DEF  = 120;
    localparam int BG_COLOUR_DEF = 0;

    // Packed slot buses are zero-extended to this width before slicing.
    localparam int BUS_MAX = 256;

    // Returns bits [idx*width +: width] of a packed bus, right-aligned.
    function automatic logic [31:0] bus_field(input logic [BUS_MAX-1:0] bus,
                                              input int unsigned       idx,
                                              input int unsigned       width);
        logic [BUS_MAX-1:0] shifted;
        logic [31:0]        mask;
        shifted = bus >> (idx * width);
        mask    = (32'd1 << width) - 32'd1;
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/sprite_blitter_rect_scan.sv
// Row-major rectangle scanner shared by the clear, erase and draw phases.
// Ports:
//   clock, resetn  - clock, async active-low reset
//   i_start        - load a new w x h scan; first pixel is presented next cycle
//   i_w, i_h       - rectangle size (must be non-zero when i_start is high)
//   o_col, o_row   - coordinates the scanner will hold next cycle (look-ahead)
//   o_valid        - look-ahead valid: next cycle is a scan pixel
//   o_last         - the pixel held this cycle is the final one of the scan
// The look-ahead outputs let the parent register its pixel outputs so that
// each pixel appears on the same cycle the scanner holds it.
module rect_scan #(
    parameter int CW = 8,
    parameter int RW = 7
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          i_start,
    input  logic [CW-1:0] i_w,
    input  logic [RW-1:0] i_h,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_valid,
    output logic          o_last
);

    logic [CW-1:0] r_col;
    logic [CW-1:0] r_w;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_h;
    logic          r_valid;
    logic          w_col_end;
    logic          w_row_end;

    assign w_col_end = (r_col == r_w - CW'(1));
    assign w_row_end = (r_row == r_h - RW'(1));
    assign o_last    = r_valid && w_col_end && w_row_end;

    // Next scan position: column fastest, stop after the bottom-right pixel.
    always_comb begin
        o_col   = r_col;
        o_row   = r_row;
        o_valid = r_valid;
        if (i_start) begin
            o_col   = '0;
            o_row   = '0;
            o_valid = 1'b1;
        end else if (r_valid) begin
            if (w_col_end) begin
                o_col = '0;
                if (w_row_end) begin
                    o_valid = 1'b0;
                end else begin
                    o_row = r_row + RW'(1);
                end
            end else begin
                o_col = r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_w     <= '0;
            r_h     <= '0;
        end else begin
            r_col   <= o_col;
            r_row   <= o_row;
            r_valid <= o_valid;
            if (i_start) begin
                r_w <= i_w;
                r_h <= i_h;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Erase/redraw engine for NUM_SPRITES rectangular sprites.
// On frame_tick it snapshots all sprite inputs, erases every rectangle drawn
// in the previous pass, then draws every enabled sprite, one pixel per cycle.
// clear_req fills the whole screen with BG_COLOUR instead.
// Ports:
//   clock, resetn        - clock, async active-low reset
//   frame_tick           - start an erase/redraw pass
//   clear_req            - start a full-screen clear (wins over frame_tick)
//   spr_en/x/y/w/h/colour - packed per-slot sprite description
//   x, y, colour, plot   - registered pixel write port to the VGA adapter
//   busy                 - a pass or clear is in progress
//   done                 - one-cycle pulse in the cycle after the last pixel
//   overrun              - frame_tick arrived while busy (one cycle later)
module sprite_blitter
    import blitter_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int DW          = 5,
    parameter int COLOUR_W    = 3,
    parameter int BG_COLOUR   = BG_COLOUR_DEF
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            frame_tick,
    input  logic                            clear_req,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    input  logic [NUM_SPRITES*XW-1:0]       spr_x,
    input  logic [NUM_SPRITES*YW-1:0]       spr_y,
    input  logic [NUM_SPRITES*DW-1:0]       spr_w,
    input  logic [NUM_SPRITES*DW-1:0]       spr_h,
    input  logic [NUM_SPRITES*COLOUR_W-1:0] spr_colour,
    output logic [XW-1:0]                   x,
    output logic [YW-1:0]                   y,
    output logic [COLOUR_W-1:0]             colour,
    output logic                            plot,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun
);

    localparam int               SW        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [SW-1:0]    LAST_SLOT = SW'(NUM_SPRITES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [SW-1:0]         r_slot;
    logic [SW-1:0]         w_next_slot;

    // Snapshot of the sprite inputs taken when a pass is accepted.
    logic [NUM_SPRITES-1:0] r_sh_en;
    logic [XW-1:0]          r_sh_x   [NUM_SPRITES];
    logic [YW-1:0]          r_sh_y   [NUM_SPRITES];
    logic [DW-1:0]          r_sh_w   [NUM_SPRITES];
    logic [DW-1:0]          r_sh_h   [NUM_SPRITES];
    logic [COLOUR_W-1:0]    r_sh_col [NUM_SPRITES];

    // Rectangles actually drawn last pass, erased at the start of the next.
    logic [NUM_SPRITES-1:0] r_prev_valid;
    logic [XW-1:0]          r_prev_x [NUM_SPRITES];
    logic [YW-1:0]          r_prev_y [NUM_SPRITES];
    logic [DW-1:0]          r_prev_w [NUM_SPRITES];
    logic [DW-1:0]          r_prev_h [NUM_SPRITES];

    logic [BUS_MAX-1:0]     w_en_bus;
    logic [BUS_MAX-1:0]     w_x_bus;
    logic [BUS_MAX-1:0]     w_y_bus;
    logic [BUS_MAX-1:0]     w_w_bus;
    logic [BUS_MAX-1:0]     w_h_bus;
    logic [BUS_MAX-1:0]     w_col_bus;

    logic                   w_start;
    logic [XW-1:0]          w_scan_w;
    logic [YW-1:0]          w_scan_h;
    logic [XW-1:0]          w_scan_col;
    logic [YW-1:0]          w_scan_row;
    logic                   w_scan_valid;
    logic                   w_scan_last;

    logic                   w_accept_tick;
    logic                   w_accept_clear;
    logic                   w_draw_ok;
    logic                   w_busy;

    logic [XW-1:0]          w_base_x;
    logic [YW-1:0]          w_base_y;
    logic [COLOUR_W-1:0]    w_pix_colour;
    logic                   w_pix_state;
    logic [XW:0]            w_sum_x;
    logic [YW:0]            w_sum_y;
    logic                   w_plot_next;

    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [COLOUR_W-1:0]    r_colour;
    logic                   r_plot;
    logic                   r_overrun;

    assign w_en_bus  = BUS_MAX'(spr_en);
    assign w_x_bus   = BUS_MAX'(spr_x);
    assign w_y_bus   = BUS_MAX'(spr_y);
    assign w_w_bus   = BUS_MAX'(spr_w);
    assign w_h_bus   = BUS_MAX'(spr_h);
    assign w_col_bus = BUS_MAX'(spr_colour);

    assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign w_draw_ok = r_sh_en[r_slot] && (r_sh_w[r_slot] != '0) && (r_sh_h[r_slot] != '0);

    rect_scan #(
        .CW (XW),
        .RW (YW)
    ) u_scan (
        .clock   (clock),
        .resetn  (resetn),
        .i_start (w_start),
        .i_w     (w_scan_w),
        .i_h     (w_scan_h),
        .o_col   (w_scan_col),
        .o_row   (w_scan_row),
        .o_valid (w_scan_valid),
        .o_last  (w_scan_last)
    );

    // Pass sequencer. FINISH accepts new requests exactly like IDLE so that
    // back-to-back frames lose no cycle.
    always_comb begin
        w_next_state   = r_state;
        w_next_slot    = r_slot;
        w_start        = 1'b0;
        w_scan_w       = '0;
        w_scan_h       = '0;
        w_accept_tick  = 1'b0;
        w_accept_clear = 1'b0;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (clear_req) begin
                    w_next_state   = ST_CLEAR;
                    w_start        = 1'b1;
                    w_scan_w       = XW'(SCREEN_W);
                    w_scan_h       = YW'(SCREEN_H);
                    w_accept_clear = 1'b1;
                end else if (frame_tick) begin
                    w_next_state  = ST_ERASE_SEL;
                    w_next_slot   = '0;
                    w_accept_tick = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (w_scan_last) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_ERASE_SEL: begin
                if (r_prev_valid[r_slot]) begin
                    w_next_state = ST_ERASE_PIX;
                    w_start      = 1'b1;
                    w_scan_w     = XW'(r_prev_w[r_slot]);
                    w_scan_h     = YW'(r_prev_h[r_slot]);
                end else if (r_slot == LAST_SLOT) begin
                    w_next_state = ST_DRAW_SEL;
                    w_next_slot  = '0;
                end else begin
                    w_next_slot = r_slot + SW'(1);
                end
            end
            ST_ERASE_PIX: begin
                if (w_scan_last) begin
                    w_next_state = (r_slot == LAST_SLOT) ? ST_DRAW_SEL : ST_ERASE_SEL;
                    w_next_slot  = (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
                end
            end
            ST_DRAW_SEL: begin
                if (w_draw_ok) begin
                    w_next_state = ST_DRAW_PIX;
                    w_start      = 1'b1;
                    w_scan_w     = XW'(r_sh_w[r_slot]);
                    w_scan_h     = YW'(r_sh_h[r_slot]);
                end else if (r_slot == LAST_SLOT) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_slot = r_slot + SW'(1);
                end
            end
            ST_DRAW_PIX: begin
                if (w_scan_last) begin
                    w_next_state = (r_slot == LAST_SLOT) ? ST_FINISH : ST_DRAW_SEL;
                    w_next_slot  = (r_slot == LAST_SLOT) ? r_slot : r_slot + SW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Describes the pixel of the coming cycle so the write port is registered
    // yet shows each pixel in the cycle that owns it. Sums are one bit wider
    // than the coordinates so off-screen pixels are clipped, never wrapped.
    always_comb begin
        w_base_x     = '0;
        w_base_y     = '0;
        w_pix_colour = COLOUR_W'(BG_COLOUR);
        w_pix_state  = 1'b0;
        case (w_next_state)
            ST_CLEAR: begin
                w_pix_state = 1'b1;
            end
            ST_ERASE_PIX: begin
                w_pix_state = 1'b1;
                w_base_x    = r_prev_x[w_next_slot];
                w_base_y    = r_prev_y[w_next_slot];
            end
            ST_DRAW_PIX: begin
                w_pix_state  = 1'b1;
                w_base_x     = r_sh_x[w_next_slot];
                w_base_y     = r_sh_y[w_next_slot];
                w_pix_colour = r_sh_col[w_next_slot];
            end
            default: begin
                w_pix_state = 1'b0;
            end
        endcase
        w_sum_x     = {1'b0, w_base_x} + {1'b0, w_scan_col};
        w_sum_y     = {1'b0, w_base_y} + {1'b0, w_scan_row};
        w_plot_next = w_pix_state && w_scan_valid
                      && (w_sum_x < (XW+1)'(SCREEN_W))
                      && (w_sum_y < (YW+1)'(SCREEN_H));
    end

    // State, snapshot, drawn-rectangle bookkeeping and registered outputs.
    // A slot's drawn rectangle is recorded in its draw-select cycle; by then
    // every erase has already been issued.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_slot       <= '0;
            r_sh_en      <= '0;
            r_prev_valid <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sh_x[i]   <= '0;
                r_sh_y[i]   <= '0;
                r_sh_w[i]   <= '0;
                r_sh_h[i]   <= '0;
                r_sh_col[i] <= '0;
                r_prev_x[i] <= '0;
                r_prev_y[i] <= '0;
                r_prev_w[i] <= '0;
                r_prev_h[i] <= '0;
            end
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_slot    <= w_next_slot;
            r_overrun <= frame_tick && w_busy;

            if (w_accept_tick) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_sh_en[i]  <= (bus_field(w_en_bus, i, 1) != 32'd0);
                    r_sh_x[i]   <= XW'(bus_field(w_x_bus, i, XW));
                    r_sh_y[i]   <= YW'(bus_field(w_y_bus, i, YW));
                    r_sh_w[i]   <= DW'(bus_field(w_w_bus, i, DW));
                    r_sh_h[i]   <= DW'(bus_field(w_h_bus, i, DW));
                    r_sh_col[i] <= COLOUR_W'(bus_field(w_col_bus, i, COLOUR_W));
                end
            end

            if (w_accept_clear) begin
                r_prev_valid <= '0;
            end else if (r_state == ST_DRAW_SEL) begin
                r_prev_valid[r_slot] <= w_draw_ok;
                r_prev_x[r_slot]     <= r_sh_x[r_slot];
                r_prev_y[r_slot]     <= r_sh_y[r_slot];
                r_prev_w[r_slot]     <= r_sh_w[r_slot];
                r_prev_h[r_slot]     <= r_sh_h[r_slot];
            end

            r_plot <= w_plot_next;
            if (w_plot_next) begin
                r_x      <= w_sum_x[XW-1:0];
                r_y      <= w_sum_y[YW-1:0];
                r_colour <= w_pix_colour;
            end else begin
                r_x      <= '0;
                r_y      <= '0;
                r_colour <= '0;
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign plot    = r_plot;
    assign busy    = w_busy;
    assign done    = (r_state == ST_FINISH);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with two sprite slots.
module tb_sprite_blitter;

    localparam int N  = 2;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int DW = 5;
    localparam int CW = 3;

    logic            clock;
    logic            resetn;
    logic            frameTick;
    logic            clearReq;
    logic [N-1:0]    sprEn;
    logic [N*XW-1:0] sprX;
    logic [N*YW-1:0] sprY;
    logic [N*DW-1:0] sprW;
    logic [N*DW-1:0] sprH;
    logic [N*CW-1:0] sprColour;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot;
    logic            busy;
    logic            done;
    logic            overrun;

    int total = 0;
    int bad   = 0;

    // Statistics gathered by runPass; cycle index 1 is the first cycle after the request.
    int  cycDone, nPlot, nBusy, nOver, overIdx, nBg, nFg, nBadCol, nOob, nDistinct;
    int  firstPlot, firstFg, lastBg, fgMinX, fgMaxX, fgMinY, fgMaxY;
    bit  seen [0:159][0:119];

    sprite_blitter #(
        .NUM_SPRITES (N),
        .XW          (XW),
        .YW          (YW),
        .DW          (DW),
        .COLOUR_W    (CW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frameTick),
        .clear_req  (clearReq),
        .spr_en     (sprEn),
        .spr_x      (sprX),
        .spr_y      (sprY),
        .spr_w      (sprW),
        .spr_h      (sprH),
        .spr_colour (sprColour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input bit en, input int px, input int py,
                            input int pw, input int ph, input int pc);
        sprEn[i]               = en;
        sprX[i*XW +: XW]       = XW'(px);
        sprY[i*YW +: YW]       = YW'(py);
        sprW[i*DW +: DW]       = DW'(pw);
        sprH[i*DW +: DW]       = DW'(ph);
        sprColour[i*CW +: CW]  = CW'(pc);
    endtask

    task automatic pulse_tick();
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
    endtask

    // Observes one pass until done (bounded), optionally pulsing frame_tick at cycle tickAt.
    task automatic run_pass(input int tickAt, input int expFg);
        int k;
        k = 1;
        cycDone = 0; nPlot = 0; nBusy = 0; nOver = 0; overIdx = 0; nBg = 0; nFg = 0;
        nBadCol = 0; nOob = 0; nDistinct = 0; firstPlot = 0; firstFg = 0; lastBg = 0;
        fgMinX = 999; fgMaxX = -1; fgMinY = 999; fgMaxY = -1;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                seen[i][j] = 1'b0;
        while (1) begin
            frameTick = (k == tickAt);
            if (busy) nBusy++;
            if (overrun) begin
                nOver++;
                overIdx = k;
            end
            if (plot) begin
                nPlot++;
                if (firstPlot == 0) firstPlot = k;
                if (x >= 160 || y >= 120) nOob++;
                else if (!seen[x][y]) begin
                    seen[x][y] = 1'b1;
                    nDistinct++;
                end
                if (colour == 0) begin
                    nBg++;
                    lastBg = k;
                end else begin
                    nFg++;
                    if (int'(colour) != expFg) nBadCol++;
                    if (firstFg == 0) firstFg = k;
                    if (int'(x) < fgMinX) fgMinX = int'(x);
                    if (int'(x) > fgMaxX) fgMaxX = int'(x);
                    if (int'(y) < fgMinY) fgMinY = int'(y);
                    if (int'(y) > fgMaxY) fgMaxY = int'(y);
                end
            end
            if (done) begin
                cycDone = k;
                break;
            end
            if (k >= 25000) break;
            step();
            k++;
        end
        frameTick = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        resetn = 1'b0; frameTick = 1'b0; clearReq = 1'b0;
        sprEn = '0; sprX = '0; sprY = '0; sprW = '0; sprH = '0; sprColour = '0;
        repeat (3) step();
        obs = {x, y, colour, plot, busy, done, overrun};
        total++; if (obs !== 22'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", obs); end
        @(negedge clock) resetn = 1'b1;
        step();
    endtask

    task automatic test_clear();
        set_slot(0, 1'b1, 144, 50, 16, 16, 3);
        set_slot(1, 1'b0, 0, 0, 4, 4, 5);
        clearReq = 1'b1; frameTick = 1'b1;
        step();
        clearReq = 1'b0; frameTick = 1'b0;
        run_pass(0, 0);
        total++; if (nPlot !== 19200) begin bad++; $display("[TB] FAIL clear_plots: got %0d want 19200", nPlot); end
        total++; if (nDistinct !== 19200) begin bad++; $display("[TB] FAIL clear_cover: got %0d want 19200", nDistinct); end
        total++; if (nBg !== 19200) begin bad++; $display("[TB] FAIL clear_bg: got %0d want 19200", nBg); end
        total++; if (nBusy !== 19200) begin bad++; $display("[TB] FAIL clear_busy: got %0d want 19200", nBusy); end
        total++; if (cycDone !== 19201) begin bad++; $display("[TB] FAIL clear_done: got %0d want 19201", cycDone); end
        total++; if (nOver !== 0) begin bad++; $display("[TB] FAIL clear_overrun: got %0d want 0", nOver); end
        repeat (4) step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("[TB] FAIL clear_tick_dropped: got %b want 00", {busy, done}); end
    endtask

    task automatic test_draw_single();
        pulse_tick();
        run_pass(0, 3);
        total++; if (cycDone !== 261) begin bad++; $display("[TB] FAIL draw_done: got %0d want 261", cycDone); end
        total++; if (nBusy !== 260) begin bad++; $display("[TB] FAIL draw_busy: got %0d want 260", nBusy); end
        total++; if (firstPlot !== 4) begin bad++; $display("[TB] FAIL draw_first_plot: got %0d want 4", firstPlot); end
        total++; if (nFg !== 256 || nBg !== 0) begin bad++; $display("[TB] FAIL draw_counts: got fg=%0d bg=%0d want 256/0", nFg, nBg); end
        total++; if (nDistinct !== 256 || nBadCol !== 0) begin bad++; $display("[TB] FAIL draw_pixels: got distinct=%0d badcol=%0d want 256/0", nDistinct, nBadCol); end
        total++; if (fgMinX !== 144 || fgMaxX !== 159 || fgMinY !== 50 || fgMaxY !== 65) begin
            bad++; $display("[TB] FAIL draw_bbox: got x%0d-%0d y%0d-%0d want x144-159 y50-65", fgMinX, fgMaxX, fgMinY, fgMaxY);
        end
        repeat (2) step();
    endtask

    task automatic test_move();
        set_slot(0, 1'b1, 143, 50, 16, 16, 3);
        pulse_tick();
        run_pass(0, 3);
        total++; if (cycDone !== 517) begin bad++; $display("[TB] FAIL move_done: got %0d want 517", cycDone); end
        total++; if (nBg !== 256 || nFg !== 256) begin bad++; $display("[TB] FAIL move_counts: got bg=%0d fg=%0d want 256/256", nBg, nFg); end
        total++; if (lastBg !== 257 || firstFg !== 260) begin bad++; $display("[TB] FAIL move_order: got lastbg=%0d firstfg=%0d want 257/260", lastBg, firstFg); end
        total++; if (fgMinX !== 143 || fgMaxX !== 158) begin bad++; $display("[TB] FAIL move_bbox: got x%0d-%0d want x143-158", fgMinX, fgMaxX); end
        repeat (2) step();
    endtask

    task automatic test_clip();
        set_slot(0, 1'b1, 152, 115, 16, 16, 3);
        pulse_tick();
        run_pass(0, 3);
        total++; if (cycDone !== 517) begin bad++; $display("[TB] FAIL clip_done: got %0d want 517", cycDone); end
        total++; if (nFg !== 40 || nOob !== 0) begin bad++; $display("[TB] FAIL clip_plots: got fg=%0d oob=%0d want 40/0", nFg, nOob); end
        total++; if (fgMinX !== 152 || fgMaxX !== 159 || fgMinY !== 115 || fgMaxY !== 119) begin
            bad++; $display("[TB] FAIL clip_bbox: got x%0d-%0d y%0d-%0d want x152-159 y115-119", fgMinX, fgMaxX, fgMinY, fgMaxY);
        end
        repeat (2) step();
    endtask

    task automatic test_overrun();
        set_slot(0, 1'b1, 144, 50, 16, 16, 3);
        pulse_tick();
        run_pass(20, 3);
        total++; if (nOver !== 1 || overIdx !== 21) begin bad++; $display("[TB] FAIL overrun_pulse: got n=%0d at=%0d want 1 at 21", nOver, overIdx); end
        total++; if (cycDone !== 517) begin bad++; $display("[TB] FAIL overrun_len: got %0d want 517", cycDone); end
        total++; if (nBg !== 40 || nFg !== 256) begin bad++; $display("[TB] FAIL overrun_counts: got bg=%0d fg=%0d want 40/256", nBg, nFg); end
        repeat (5) step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("[TB] FAIL overrun_no_repass: got %b want 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        pulse_tick();
        run_pass(0, 3);
        frameTick = 1'b1;
        step();
        frameTick = 1'b0;
        total++; if ({busy, done, overrun} !== 3'b100) begin bad++; $display("[TB] FAIL b2b_accept: got %b want 100", {busy, done, overrun}); end
        run_pass(0, 3);
        total++; if (cycDone !== 517 || nBg !== 256 || nFg !== 256) begin
            bad++; $display("[TB] FAIL b2b_pass: got done=%0d bg=%0d fg=%0d want 517/256/256", cycDone, nBg, nFg);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_pass();
        logic [21:0] obs;
        int k;
        pulse_tick();
        k = 0;
        while (!(plot && colour == 3) && k < 600) begin
            step();
            k++;
        end
        total++; if (k >= 600) begin bad++; $display("[TB] FAIL midreset_reach_draw: got %0d cycles want <600", k); end
        #2 resetn = 1'b0;
        #1 obs = {x, y, colour, plot, busy, done, overrun};
        total++; if (obs !== 22'd0) begin bad++; $display("[TB] FAIL midreset_outputs: got %h want 0", obs); end
        @(negedge clock) resetn = 1'b1;
        repeat (2) step();
        pulse_tick();
        run_pass(0, 3);
        total++; if (cycDone !== 261 || nBg !== 0 || firstPlot !== 4) begin
            bad++; $display("[TB] FAIL midreset_no_erase: got done=%0d bg=%0d first=%0d want 261/0/4", cycDone, nBg, firstPlot);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_draw_single();
        test_move();
        test_clip();
        test_overrun();
        test_back_to_back();
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised erase/redraw engine for N rectangular sprites on the 160x120 VGA frame buffer. On each frame tick it snapshots all sprite positions, erases every sprite drawn last frame, then draws every enabled sprite. It emits one pixel write per cycle to the VGA adapter's x/y/colour/plot port. It sits between the game-logic FSM, which now only updates coordinates, and the VGA adapter.

## Interface
Parameters:
- NUM_SPRITES, 4: sprite slots.
- XW, 8: x coordinate width.
- YW, 7: y coordinate width.
- SCREEN_W, 160: visible width. Pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 120: visible height. Pixels with y ≥ SCREEN_H are clipped.
- DW, 5: sprite width/height field width. Maximum size is 2^DW−1.
- COLOUR_W, 3: colour width.
- BG_COLOUR, 0: erase/clear colour.

Ports:
- clock, in, 1: system clock (CLOCK_50 at top).
- resetn, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-cycle frame pulse.
- clear_req, in, 1: one-cycle pulse requesting a full-screen fill with BG_COLOUR.
- spr_en, in, NUM_SPRITES: per-slot enable.
- spr_x, in, NUM_SPRITES*XW: packed x coordinates; slot i at [i*XW +: XW].
- spr_y, in, NUM_SPRITES*YW: packed y coordinates.
- spr_w, in, NUM_SPRITES*DW: packed widths.
- spr_h, in, NUM_SPRITES*DW: packed heights.
- spr_colour, in, NUM_SPRITES*COLOUR_W: packed colours.
- x, out, XW: pixel x.
- y, out, YW: pixel y.
- colour, out, COLOUR_W: pixel colour.
- plot, out, 1: pixel write strobe.
- busy, out, 1: high while a pass is running.
- done, out, 1: one-cycle pulse when a pass ends.
- overrun, out, 1: one-cycle pulse when frame_tick arrives while busy.

## Operation
- Reset: all outputs 0, state IDLE, prev_valid[*] cleared. The screen is not erased; the top level issues clear_req after reset.
- States: IDLE, CLEAR, ERASE_SEL, ERASE_PIX, DRAW_SEL, DRAW_PIX, FINISH.
- IDLE, clear_req=1 → CLEAR. Scans row-major over SCREEN_W×SCREEN_H with colour=BG_COLOUR and plot=1, clears prev_valid[*], then → FINISH.
- IDLE, frame_tick=1 and clear_req=0 → ERASE_SEL, slot 0. On the same edge, all spr_* inputs are captured into shadow registers. Inputs may change freely afterwards.
- Simultaneous clear_req and frame_tick in IDLE: clear wins and the tick is dropped. overrun does not pulse.
- ERASE_SEL, slot i: one cycle with plot=0.
  - If prev_valid[i]=1, go to ERASE_PIX over the prev_x/y/w/h rectangle with BG_COLOUR.
  - Otherwise advance to slot i+1.
  - After slot N−1 → DRAW_SEL, slot 0.
- DRAW_SEL, slot i: one cycle with plot=0.
  - If shadow en=1, w≠0 and h≠0, go to DRAW_PIX with the shadow colour.
  - On leaving slot i, prev_* ← shadow values and prev_valid[i] ← that condition.
  - After slot N−1 → FINISH.
- PIX scan: row-major, column fastest. x = base_x + col and y = base_y + row, computed at XW+1 / YW+1 bits. A pixel is clipped if the sum ≥ SCREEN_W / SCREEN_H.
  - Clipped pixel: plot=0; it still consumes its cycle. The truncated x/y value is don't-care.
  - No wrap-around is ever plotted.
- Erasing all slots before drawing any means overlapping sprites are never corrupted by another sprite's erase. Among overlapping draws, the later slot index wins.
- FINISH: one cycle with done=1 and busy=0, then → IDLE.
- frame_tick or clear_req outside IDLE/FINISH: ignored. frame_tick in that window pulses overrun one cycle later. clear_req in that window is dropped silently.
- Reset asserted mid-pass: immediate return to the reset state. Partial pixels stay on screen.

## Timing
- x, y, colour and plot are registered. The value shown in a PIX cycle is that cycle's pixel.
- Tick sampled at cycle T → busy=1 from T+1. The first ERASE_SEL is at T+1 and its first pixel at T+2.
- Pass length, from T+1 through the last pixel: 2·N select cycles + Σ prev w·h + Σ drawn w·h. FINISH follows in the next cycle.
- Clear duration: SCREEN_W·SCREEN_H pixel cycles, then FINISH.
- busy is high from the first SEL/CLEAR cycle through the last pixel cycle.
- A frame_tick in the FINISH cycle is accepted; the next pass starts the following cycle.

## Structure
- Package blitter_pkg holds:
  - the state encoding localparams;
  - the default screen constants 160/120;
  - the BG colour constant;
  - helper functions that slice the packed buses.
- Sub-module rect_scan: given w and h and a start pulse, produces col, row, a valid flag and a last flag (one cycle per pixel). It is instantiated once and shared by the CLEAR, ERASE and DRAW phases.

## Test plan
- Reset then clear_req: exactly 19200 plot=1 cycles with colour 0 covering every (x,y), then a done pulse. busy is high for 19200 cycles.
- N=2, slot0 at (144,50) 16×16 colour 3, slot1 disabled, one tick:
  - 2 cycles of SEL for the erase phase with no plots;
  - 1 cycle of draw SEL, then 256 plots with colour 3 covering x 144–159 and y 50–65;
  - 1 cycle of draw SEL for slot1;
  - done at T+261.
- Second tick with slot0 moved to (143,50): 256 BG plots at the old rectangle first, then 256 colour-3 plots at the new one.
- Slot at (152,115) 16×16: only the 8×5 on-screen pixels have plot=1. The cycle count is still 256.
- frame_tick pulsed mid-pass: overrun pulses 1 cycle later, the pass length is unchanged and no second pass starts.
- resetn low mid-DRAW_PIX: all outputs read 0 asynchronously. After release, the next tick performs no erase (prev_valid cleared).
